// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V encodings and data-memory port FSM states
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/riscv_data_mem_port_if.sv
// rtl/riscv_data_mem_port_if.sv - word-wide data memory request/response bus
interface riscv_data_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/riscv_load_extend.sv
// rtl/riscv_load_extend.sv - load lane select and sign/zero extension
module riscv_load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_data_mem_port.sv
// rtl/riscv_data_mem_port.sv - stalling load/store port to word-wide data memory
// RISCV_MISALIGN_TRAP_EN: reject misaligned half/word accesses instead of aligning them.
module riscv_data_mem_port
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [2:0]           funct3,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          wdata,
  output logic                 stall,
  output logic [31:0]          rdata,
  output logic                 access_err,
  riscv_data_mem_port_if.master mem
);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_lo;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic              w_start;
  logic              w_legal;
  logic              w_reject;
  logic [1:0]        w_lo;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ext;

  assign w_start = MemRead | MemWrite;
  assign w_legal = f3_legal(funct3);

`ifdef RISCV_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_reject   = ~w_legal | w_misalign;
`else
  assign w_reject   = ~w_legal;
`endif

  // Lane offset is pre-aligned so a misaligned access degrades to its natural slot.
  always_comb begin
    w_lo    = addr[1:0];
    w_be    = 4'b0000;
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_lo    = {addr[1], 1'b0};
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{wdata[15:0]}};
      end
      2'b10: begin
        w_lo = 2'b00;
        w_be = 4'b1111;
      end
      default: w_be = 4'b0000;
    endcase
    if (!w_legal) begin
      w_be = 4'b0000;
    end
  end

  riscv_load_extend u_load_extend (
    .i_funct3  (r_f3),
    .i_addr_lo (r_lo),
    .i_word    (mem.mem_rdata),
    .o_data    (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          stall       = 1'b1;
          w_state_nxt = w_reject ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (mem.mem_ready) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_lo    <= 2'b00;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_start) begin
        r_we    <= MemWrite;
        r_f3    <= funct3;
        r_lo    <= w_lo;
        r_err   <= (MemRead & MemWrite) | w_reject;
        r_addr  <= {addr[ADDR_W-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        if (w_reject) begin
          r_rdata <= 32'h0;
        end
      end
      if ((r_state == ST_ACCESS) && mem.mem_ready && !r_we) begin
        r_rdata <= w_ext;
      end
    end
  end

  assign mem.mem_req   = (r_state == ST_ACCESS);
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_be    = r_be;
  assign mem.mem_wdata = r_wdata;
  assign rdata         = r_rdata;
  assign access_err    = (r_state == ST_DONE) && r_err;

endmodule

// File: doc/riscv_data_mem_port.md
# riscv_data_mem_port

Responder side of the load/store control path: consumes the `MemRead`/`MemWrite` strobes driven by the control unit, together with the ALU-computed address, store data and `funct3`. It performs byte/half/word accesses against a word-wide data memory with variable wait states, and stalls the core until the access completes. It returns sign- or zero-extended load data to the write-back mux selected by `MemToReg`.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width presented by the datapath.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request from the control unit.
- `MemWrite`  in  1  store request from the control unit.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  ADDR_W  byte address from the ALU.
- `wdata`  in  32  store data (rs2).
- `stall`  out  1  hold PC and pipeline registers.
- `rdata`  out  32  extended load data; valid in DONE.
- `access_err`  out  1  one-cycle pulse when an access is rejected.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- `mem_be`  out  4  byte enables (bit i = byte lane i).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  memory completes the request this cycle.
- `mem_rdata`  in  32  read word; valid when `mem_ready` is high on a read.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, with `MemRead|MemWrite` high:
  - Latch `addr`, `wdata`, `funct3` and direction.
  - Move to ACCESS.
  - Assert `stall` combinationally in the same cycle.
- IDLE, with neither strobe high: `stall` = 0.
- ACCESS:
  - `mem_req` = 1; `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are stable from the latched values.
  - On `mem_ready`, capture extended read data into `rdata` and move to DONE.
  - `stall` = 1.
- DONE:
  - `stall` = 0 and `rdata` is held; the core advances on this edge.
  - Next state is IDLE unconditionally, so back-to-back accesses cost one IDLE cycle minimum.
- Both strobes high: treated as a store and `access_err` pulses. The store is still performed.
- Illegal `funct3` (011, 110, 111):
  - No memory request is made.
  - `access_err` pulses, `rdata` = 0 and the FSM goes IDLE→DONE.
- Store lanes:
  - SB: `mem_be` = 0001 << addr[1:0]; `mem_wdata` = {4{wdata[7:0]}}.
  - SH: `mem_be` = 0011 << {addr[1],1'b0}; `mem_wdata` = {2{wdata[15:0]}}.
  - SW: `mem_be` = 1111; `mem_wdata` = `wdata`.
- Loads: `mem_be` follows the same lane rule. The selected byte/half is shifted to bit 0, then sign-extended (B, H) or zero-extended (BU, HU). W passes through.

## Timing
- Reset values: state IDLE; `stall` = 0; `rdata` = 0; `access_err` = 0; `mem_req` = 0; `mem_we` = 0; `mem_addr` = 0; `mem_be` = 0; `mem_wdata` = 0.
- Latency: strobe cycle, then N ≥ 1 ACCESS cycles (ending with the `mem_ready` cycle), then 1 DONE cycle. Minimum total stall is 2 cycles.
- `mem_ready` is ignored outside ACCESS.
- `mem_req` deasserts on the edge following `mem_ready`.
- Reset asserted in ACCESS: `mem_req` drops the next cycle; the in-flight access is abandoned and no data is captured.
- `access_err` is high exactly for the DONE cycle of the rejected access.

## Configuration
- Macro: `RISCV_MISALIGN_TRAP_EN`.
- Defined:
  - Halfword access with addr[0] = 1, or word access with addr[1:0] ≠ 00, is rejected.
  - Rejected means no `mem_req`, `access_err` pulses, and `rdata` = 0.
- Undefined:
  - Offending low address bits are forced to zero (half: addr[0]; word: addr[1:0]) and the access proceeds normally.
  - `access_err` never pulses for alignment.

## Structure
- Shared package `riscv_pkg`:
  - `funct3` load/store encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - Opcode localparams already used by the control unit.
  - FSM state enum `mem_state_t`.
- One sub-module: `riscv_load_extend`, a combinational lane select and extension unit taking `funct3`, addr[1:0] and the raw word.

## Test plan
- LW at 0x100, `mem_rdata` = 0xDEADBEEF, `mem_ready` after 3 ACCESS cycles → `stall` high 4 cycles, then DONE with `rdata` = 0xDEADBEEF, `mem_addr` = 0x100, `mem_be` = 1111.
- LB at 0x103, word 0x80FF_FF7F → `rdata` = 0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x202, `wdata` = 0x1234ABCD → `mem_we` = 1, `mem_be` = 1100, `mem_wdata` = 0xABCDABCD, `mem_addr` = 0x200.
- LW at 0x101:
  - With the macro defined → no `mem_req`, `access_err` pulses, `rdata` = 0.
  - Without the macro → `mem_addr` = 0x100, normal completion.
- `rst` asserted during the 2nd ACCESS cycle → the next cycle shows `mem_req` = 0, `stall` = 0 and state IDLE; a late `mem_ready` has no effect.
- `funct3` = 111 with `MemRead` → no `mem_req`, `access_err` pulses, `stall` high for exactly 1 cycle.
